// File: rtl/jesd_sysref_sync_ctrl.sv
// jesd_sysref_sync_ctrl: SYSREF synchronise/gate/period-measure and SYNC~ output control
module jesd_sysref_sync_ctrl #(
    parameter int NUM_LINKS   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 16,
    parameter int LOSS_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sysref_in,
    input  logic                 sysref_mode,
    input  logic                 sysref_arm,
    output logic                 sysref_out,
    output logic                 sysref_captured,
    output logic [PERIOD_W-1:0]  sysref_period,
    output logic                 sysref_period_stable,
    input  logic [NUM_LINKS-1:0] rx_sync,
    input  logic [NUM_LINKS-1:0] sync_inv,
    input  logic                 sync_combine,
    input  logic                 sync_force,
    output logic [NUM_LINKS-1:0] sync_out,
    output logic [LOSS_W-1:0]    link_loss_cnt
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURED} state_t;
    localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
    localparam logic [LOSS_W-1:0]   LOSS_MAX = '1;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q, rise, sat;
    logic                   out_q, out_d;
    logic [PERIOD_W-1:0]    cnt_q, cnt_d, period_q, period_d;
    logic                   seen_q, stable_q, stable_d;
    logic [NUM_LINKS-1:0]   sync_out_q, sync_out_d;
    logic                   comb_q, comb_d;
    logic [LOSS_W-1:0]      loss_q, loss_d;
    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign sat  = cnt_q == CNT_MAX;
    // One-shot gating FSM; continuous mode parks it in IDLE and passes every rise
    always_comb begin
        state_d = state_q;
        out_d   = 1'b0;
        if (!sysref_mode) begin
            state_d = IDLE;
            out_d   = rise;
        end else begin
            case (state_q)
                IDLE:     state_d = sysref_arm ? ARMED : IDLE;
                ARMED:    begin
                    state_d = rise ? CAPTURED : ARMED;
                    out_d   = rise;
                end
                CAPTURED: state_d = sysref_arm ? ARMED : CAPTURED;
                default:  state_d = IDLE;
            endcase
        end
    end
    // Edge-to-edge period counter; the first edge after reset only starts timing
    always_comb begin
        cnt_d    = rise ? PERIOD_W'(1) : (sat ? cnt_q : cnt_q + PERIOD_W'(1));
        period_d = (rise && seen_q) ? cnt_q : period_q;
        stable_d = (rise && seen_q) ? ((cnt_q == period_q) && !sat) : (sat ? 1'b0 : stable_q);
    end
    // SYNC~ select/force/invert and link-loss detection on the forced AND of all links
    always_comb begin
        for (int l = 0; l < NUM_LINKS; l++)
            sync_out_d[l] = ((sync_combine ? &rx_sync : rx_sync[l]) & ~sync_force) ^ sync_inv[l];
        comb_d = &rx_sync & ~sync_force;
        loss_d = (comb_q && !comb_d && (loss_q != LOSS_MAX)) ? loss_q + LOSS_W'(1) : loss_q;
    end
    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            dly_q      <= 1'b0;
            state_q    <= IDLE;
            out_q      <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            seen_q     <= 1'b0;
            stable_q   <= 1'b0;
            sync_out_q <= '0;
            comb_q     <= 1'b0;
            loss_q     <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sysref_in};
            dly_q      <= sync_q[SYNC_STAGES-1];
            state_q    <= state_d;
            out_q      <= out_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            seen_q     <= seen_q | rise;
            stable_q   <= stable_d;
            sync_out_q <= sync_out_d;
            comb_q     <= comb_d;
            loss_q     <= loss_d;
        end
    end
    assign sysref_out           = out_q;
    assign sysref_captured      = state_q == CAPTURED;
    assign sysref_period        = period_q;
    assign sysref_period_stable = stable_q;
    assign sync_out             = sync_out_q;
    assign link_loss_cnt        = loss_q;
endmodule
